ppg_fifo_ctrl: RTL

Read-side scheduler for the PPG sample FIFO in the BPM_System PPG interface. It forwards sensor samples into the FIFO and tracks its fill level. It drains the FIFO in bursts of `BURST` samples, or flushes a partial burst after a timeout, and presents each sample to the BPM processing stage over a valid/ready stream. It also keeps the FIFO's overwrite-when-full behaviour from colliding with reads.

---
 rtl/ppg_pkg.sv | 18 +
 rtl/ppg_flush_timer.sv | 34 +++
 rtl/ppg_fifo_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ppg_pkg.sv
// rtl/ppg_pkg.sv - shared types and defaults for the PPG FIFO read-side controller
// Contents:
//   PPG_WIDTH, PPG_DEPTH, PPG_BURST : default sample width, FIFO depth, burst length
//   ppg_ctrl_state_t                : read scheduler states
package ppg_pkg;

  localparam int PPG_WIDTH = 10;
  localparam int PPG_DEPTH = 32;
  localparam int PPG_BURST = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } ppg_ctrl_state_t;

endpackage

// File: rtl/ppg_flush_timer.sv
// rtl/ppg_flush_timer.sv - idle counter that triggers a partial-burst flush
// Only instantiated when PPG_CTRL_TIMEOUT_EN is defined.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset
//   run     : count while high
//   clear   : synchronous clear, wins over run
//   expired : high while the count sits at TIMEOUT-1
module ppg_flush_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  // Saturates at TIMEOUT-1 so a lingering run cannot wrap the counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ppg_fifo_ctrl.sv
// rtl/ppg_fifo_ctrl.sv - read-side burst scheduler for the PPG sample FIFO
// Optional feature: PPG_CTRL_TIMEOUT_EN builds the partial-flush timer.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   sample_valid, sample_data: sensor sample strobe and data
//   fifo_wr_en, fifo_din     : FIFO write side, combinational pass-through
//   fifo_rd_en, fifo_dout    : FIFO read side, dout valid one cycle after rd_en
//   fifo_full, fifo_empty    : FIFO flags
//   m_valid, m_ready, m_data, m_last : output sample stream
//   overrun                  : pulse the cycle after a write lands on a full FIFO
//   level                    : FIFO occupancy mirrored by this block
module ppg_fifo_ctrl
  import ppg_pkg::*;
#(
  parameter int WIDTH   = PPG_WIDTH,
  parameter int DEPTH   = PPG_DEPTH,
  parameter int BURST   = PPG_BURST,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [WIDTH-1:0]       sample_data,
  output logic                   fifo_wr_en,
  output logic [WIDTH-1:0]       fifo_din,
  output logic                   fifo_rd_en,
  input  logic [WIDTH-1:0]       fifo_dout,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_last,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;

  ppg_ctrl_state_t state, state_nxt;
  logic [LW-1:0]   remaining, remaining_nxt;
  logic            collision;
  logic            timer_fire;

  // The mirrored level already tells us when data is present.
  logic unused_empty;
  assign unused_empty = fifo_empty;

  assign fifo_wr_en = sample_valid;
  assign fifo_din   = sample_data;

  // A write on a full FIFO advances its read pointer (overwrite), so a read
  // in the same cycle would advance it twice; such reads are deferred.
  assign collision = sample_valid && fifo_full;

`ifdef PPG_CTRL_TIMEOUT_EN
  logic idle_run;
  assign idle_run = (state == IDLE) && (level != '0);

  ppg_flush_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_flush_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (idle_run),
    .clear  (!idle_run),
    .expired(timer_fire)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign timer_fire     = 1'b0;
`endif

  assign m_valid = (state == HOLD);
  assign m_last  = m_valid && (remaining == LW'(1));

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    fifo_rd_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (level >= LW'(BURST)) begin
          remaining_nxt = LW'(BURST);
          state_nxt     = ISSUE;
        end else if (timer_fire && (level != '0)) begin
          remaining_nxt = level;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        fifo_rd_en = !collision;
        if (!collision) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (m_ready) begin
          remaining_nxt = remaining - LW'(1);
          state_nxt     = (remaining == LW'(1)) ? IDLE : ISSUE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      m_data    <= '0;
      overrun   <= 1'b0;
      level     <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      overrun   <= collision;
      if (state == CAPTURE) begin
        m_data <= fifo_dout;
      end
      // A write on a full FIFO displaces a sample, so occupancy is unchanged.
      if (fifo_wr_en && !fifo_full && !fifo_rd_en) begin
        level <= level + LW'(1);
      end else if (fifo_rd_en && !fifo_wr_en) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule
